keypad_scanner: RTL
===================

# keypad_scanner

Matrix-keypad front end for the calculator datapath. Drives the 5×4 key matrix one row at a time and samples the columns. Debounces both press and release, then emits a one-cycle `newkey` pulse with a 5-bit `keycode` in the encoding the keypad interpreter consumes. It is the producer side of the `newkey`/`keycode` interface.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each row is driven before its columns are sampled; legal range ≥ 4.
- `DEBOUNCE_CNT`, default 8: consecutive identical samples required to accept a press or a release; legal range ≥ 2.
- `REPEAT_CNT`, default 64: samples between repeated pulses while a key is held; used only with `KEYPAD_AUTOREPEAT_EN`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `rows`  out  5  row drive, active-low, exactly one bit low at all times.
- `cols`  in  4  column sense, active-low (pulled up off-chip), asynchronous.
- `newkey`  out  1  high for exactly one cycle per accepted keypress.
- `keycode`  out  5  code of the last accepted key; held between pulses.
- `keydown`  out  1  high from the `newkey` cycle until the release is accepted.

## Operation
- `cols` passes through a 2-flop synchronizer before any use.
- A sample is the synchronized `cols` taken in the last cycle of a `SCAN_DIV` period.
- A sample is "active" when any bit is 0. The active column is the lowest-index 0 bit.
- Key map (row r, col c):
  - rows 0–3 map to hex digit h = 4r+c, with `keycode` = {1'b1, h[3:0]}.
  - row 4, col 0 = ADD 5'b01010.
  - row 4, col 1 = SUB 5'b00011.
  - row 4, col 2 = MULT 5'b00010.
  - row 4, col 3 = EQUALS 5'b00100.
- FSM states:
  - SCAN: the row advances 0→1→2→3→4→0 every `SCAN_DIV` cycles. An active sample captures the row, the full 4-bit pattern and the active column, sets debounce count = 1, and moves to PRESS_DB.
  - PRESS_DB: the row is held. A sample equal to the captured pattern increments the count. On reaching `DEBOUNCE_CNT`, go to HELD, pulse `newkey`, load `keycode`, set `keydown`. A mismatching sample (including all-ones) returns to SCAN at the next row, with no pulse.
  - HELD: the row is held. An all-ones sample sets release count = 1 and moves to REL_DB. Any other sample stays in HELD, even if the pattern has changed; a second key is ignored.
  - REL_DB: each all-ones sample increments the release count. An active sample returns to HELD. On reaching `DEBOUNCE_CNT`, clear `keydown` and return to SCAN at row 0.
- Only one key is reported per press; simultaneous keys in the same row resolve to the lowest column.
- Counters saturate, never wrap. The `SCAN_DIV` divider runs continuously in every state.

## Timing
- Reset values:
  - `rows` = 5'b11110
  - `newkey` = 0
  - `keycode` = 5'b00000
  - `keydown` = 0
  - state SCAN, row 0, all counters 0.
- Reset assertion takes effect immediately, mid-debounce or mid-hold. No pulse is emitted across reset.
- `newkey` and the new `keycode` value appear together, in the cycle after the `DEBOUNCE_CNT`-th matching sample. That is (`DEBOUNCE_CNT`−1)·`SCAN_DIV`+1 cycles after the first active sample.
- `keycode` changes only in a `newkey` cycle.
- `rows` changes only at `SCAN_DIV` period boundaries, immediately after the sample cycle.
- Press latency from the physical closure of a stable key is at most (5+`DEBOUNCE_CNT`)·`SCAN_DIV`+2 cycles.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In HELD, count active samples. Every `REPEAT_CNT` samples, pulse `newkey` again with the unchanged `keycode`.
  - The count resets on entry to HELD and on any REL_DB→HELD return.
- Not defined: exactly one `newkey` per press, regardless of hold duration. `REPEAT_CNT` is unused.

## Test plan
Bench uses `SCAN_DIV`=4 and `DEBOUNCE_CNT`=3.
- Reset, then no keys for 40 cycles -> `rows` cycles 11110,11101,11011,10111,01111 every 4 cycles; `newkey` stays 0; `keycode` = 00000.
- Clean press of row 2 col 1 (`cols`=1101 while row 2 is low), held 100 cycles, then released -> exactly one `newkey`, `keycode` = 5'b11001. `keydown` is high until 3 all-ones samples, then low, and scan restarts at row 0.
- Press EQUALS (row 4 col 3) -> `keycode` = 5'b00100. Press ADD (row 4 col 0) -> 5'b01010. One pulse each.
- Bouncing press on row 1 col 0: active, inactive, then stable -> no pulse at the bounce. A pulse with `keycode` = 5'b10100 follows 3 consecutive matching samples.
- Row 0, `cols`=0101 (cols 1 and 3 both pressed) -> `keycode` = 5'b10001.
- `rst_n` low while in HELD -> all outputs return to reset values on the next edge of `rst_n`, independent of `clk`. No `newkey` after release. With `KEYPAD_AUTOREPEAT_EN`, `REPEAT_CNT`=5, and a 60-sample hold -> the first pulse plus repeats every 5 samples.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 5x4 active-low key matrix and debounces press and release.
// Latency: newkey one cycle after the DEBOUNCE_CNT-th matching column sample.
// No backpressure: newkey is a single-cycle pulse. `KEYPAD_AUTOREPEAT_EN adds held-key repeats.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8,
  parameter int REPEAT_CNT   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [4:0] rows,
  input  logic [3:0] cols,
  output logic       newkey,
  output logic [4:0] keycode,
  output logic       keydown
);

  localparam int DIVW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DBW  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE_CNT);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_CNT < 1) begin : g_bad_params
    $error("keypad_scanner: illegal parameter value");
  end

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

  state_t          state_q, state_d;
  logic [2:0]      row_q, row_d;
  logic [3:0]      pat_q, pat_d;
  logic [1:0]      col_q, col_d;
  logic [DBW-1:0]  cnt_q, cnt_d;
  logic [DIVW-1:0] div_q;
  logic [3:0]      cs1, cs2;
  logic            newkey_d, keydown_d;
  logic [4:0]      keycode_d;
  logic            samp, active;
  logic [2:0]      nxt_row;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPW = (REPEAT_CNT > 2) ? $clog2(REPEAT_CNT) : 1;
  localparam logic [RPW-1:0] REP_LAST = RPW'(REPEAT_CNT - 1);
  logic [RPW-1:0] rep_q, rep_d;
`endif

  function automatic logic [1:0] low_col(input logic [3:0] p);
    if (!p[0])      return 2'd0;
    else if (!p[1]) return 2'd1;
    else if (!p[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  // Rows 0-3 are hex digits 4r+c; row 4 holds the operator keys.
  function automatic logic [4:0] encode(input logic [2:0] r, input logic [1:0] c);
    if (r == 3'd4) begin
      case (c)
        2'd0:    return 5'b01010;
        2'd1:    return 5'b00011;
        2'd2:    return 5'b00010;
        default: return 5'b00100;
      endcase
    end
    return {1'b1, r[1:0], c};
  endfunction

  assign samp    = (div_q == DIV_LAST);
  assign active  = ~&cs2;
  assign nxt_row = (row_q == 3'd4) ? 3'd0 : row_q + 3'd1;
  assign rows    = ~(5'b00001 << row_q);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    pat_d     = pat_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    newkey_d  = 1'b0;
    keycode_d = keycode;
    keydown_d = keydown;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d     = rep_q;
`endif
    if (samp) begin
      unique case (state_q)
        SCAN: begin
          if (active) begin
            pat_d   = cs2;
            col_d   = low_col(cs2);
            cnt_d   = DBW'(1);
            state_d = PRESS_DB;
          end else begin
            row_d = nxt_row;
          end
        end
        PRESS_DB: begin
          if (cs2 != pat_q) begin
            state_d = SCAN;
            row_d   = nxt_row;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST - 1'b1) begin
            state_d   = HELD;
            cnt_d     = '0;
            newkey_d  = 1'b1;
            keycode_d = encode(row_q, col_q);
            keydown_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d     = '0;
`endif
          end else if (cnt_q < DB_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD: begin
          // A changed but still active pattern is a second key and is ignored.
          if (!active) begin
            cnt_d   = DBW'(1);
            state_d = REL_DB;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep_q == REP_LAST) begin
            newkey_d = 1'b1;
            rep_d    = '0;
          end else begin
            rep_d = rep_q + 1'b1;
          end
`endif
        end
        REL_DB: begin
          if (active) begin
            state_d = HELD;
            cnt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d   = '0;
`endif
          end else if (cnt_q == DB_LAST - 1'b1) begin
            state_d   = SCAN;
            row_d     = 3'd0;
            cnt_d     = '0;
            keydown_d = 1'b0;
          end else if (cnt_q < DB_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs1     <= 4'b1111;
      cs2     <= 4'b1111;
      div_q   <= '0;
      state_q <= SCAN;
      row_q   <= 3'd0;
      pat_q   <= 4'b1111;
      col_q   <= 2'd0;
      cnt_q   <= '0;
      newkey  <= 1'b0;
      keycode <= 5'b00000;
      keydown <= 1'b0;
    end else begin
      cs1     <= cols;
      cs2     <= cs1;
      div_q   <= samp ? '0 : div_q + 1'b1;
      state_q <= state_d;
      row_q   <= row_d;
      pat_q   <= pat_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      newkey  <= newkey_d;
      keycode <= keycode_d;
      keydown <= keydown_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`endif

endmodule
